serial_rx_deframer: RTL and testbench

//   Oversampling asynchronous-serial receive front end: synchronises the raw dataIn pin, detects

---
 rtl/serial_pkg.sv | 20 ++
 rtl/oversample_tick_gen.sv | 28 ++
 rtl/serial_rx_deframer.sv | 153 +++++++++++++++
 tb/tb_serial_rx_deframer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial framing types and constants
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } serial_state_t;

    localparam int RX_WORD_W      = 10;
    localparam int FRAME_ERR_BIT  = 9;
    localparam int PARITY_ERR_BIT = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/oversample_tick_gen.sv
// rtl/oversample_tick_gen.sv - oversample tick divider, restartable on a start edge
module oversample_tick_gen #(
    parameter int CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || r_cnt == TC) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == TC);

endmodule

// File: rtl/serial_rx_deframer.sv
// rtl/serial_rx_deframer.sv - oversampled async serial receiver with one-word holding register
module serial_rx_deframer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_TICK = 27,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [RX_WORD_W-1:0] rx_word,
    output logic                 rx_valid,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 r_sync1, r_sync2, r_rxs_prev;
    serial_state_t        r_state, w_next;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0, r_s1;
    logic                 r_par_err;
    logic [RX_WORD_W-1:0] r_word;
    logic                 r_valid, r_overrun;

    logic                 w_fall, w_restart, w_tick, w_maj;
    logic                 w_at_sample, w_at_end, w_complete;
    logic [RX_WORD_W-1:0] w_new_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rx_in;
            r_sync2    <= r_sync1;
            r_rxs_prev <= r_sync2;
        end
    end

    assign w_fall    = r_rxs_prev & ~r_sync2;
    assign w_restart = (r_state == ST_IDLE) & w_fall;

    oversample_tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .restart(w_restart),
        .tick   (w_tick)
    );

    // Third vote is the live synchronised value at the last sample tick.
    assign w_maj       = majority3(r_s0, r_s1, r_sync2);
    assign w_at_sample = w_tick & (r_tick_cnt == T_S2);
    assign w_at_end    = w_tick & (r_tick_cnt == T_END);
    assign w_complete  = (r_state == ST_STOP) & w_at_sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_fall) w_next = ST_START;
            ST_START: begin
                if (w_at_sample && w_maj) w_next = ST_IDLE;
                else if (w_at_end)        w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_at_end && r_bit_idx == LAST_BIT)
                    w_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_at_end)    w_next = ST_STOP;
            ST_STOP:   if (w_at_sample) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_par_err  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            if (w_fall) r_par_err <= 1'b0;
        end else if (w_tick) begin
            r_tick_cnt <= (r_tick_cnt == T_END) ? '0 : r_tick_cnt + 1'b1;
            if (r_tick_cnt == T_S0) r_s0 <= r_sync2;
            if (r_tick_cnt == T_S1) r_s1 <= r_sync2;
            if (w_at_sample && r_state == ST_DATA)
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (w_at_sample && r_state == ST_PARITY)
                r_par_err <= (^r_shift) ^ w_maj;
            if (w_at_end && r_state == ST_DATA)
                r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    always_comb begin
        w_new_word                 = '0;
        w_new_word[DATA_BITS-1:0]  = r_shift;
        w_new_word[PARITY_ERR_BIT] = r_par_err;
        w_new_word[FRAME_ERR_BIT]  = ~w_maj;
    end

    // An ack arriving with a completion frees the slot for the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || rx_ack) begin
                r_word  <= w_new_word;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (rx_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign rx_word  = r_word;
    assign rx_valid = r_valid;
    assign overrun  = r_overrun;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_deframer.sv
// tb/tb_serial_rx_deframer.sv - directed self-checking bench for serial_rx_deframer
module tb_serial_rx_deframer;

    localparam int CPT       = 8;
    localparam int OS        = 16;
    localparam int BIT_CYC   = CPT * OS;
    localparam int FRAME_CYC = BIT_CYC * 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ack = 1'b0;
    logic [9:0] rx_word;
    logic       rx_valid, overrun, busy;

    int n_checks = 0;
    int n_errors = 0;

    serial_rx_deframer #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (OS),
        .DATA_BITS    (8),
        .PARITY_EN    (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_in   (rx_in),
        .rx_ack  (rx_ack),
        .rx_word (rx_word),
        .rx_valid(rx_valid),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ack;
        logic [9:0] exp_word;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        rx_in = 1'b1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int c = 0;
        while (!rx_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, {15'd0, rx_valid}, 16'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h41, 1'b0, 1'b1, 1'b1, 10'h041, 1'b1, 1'b0};
        vecs[1] = '{8'h41, 1'b1, 1'b1, 1'b1, 10'h141, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 10'h255, 1'b1, 1'b0};
        vecs[3] = '{8'h31, 1'b1, 1'b1, 1'b0, 10'h031, 1'b1, 1'b0};
        vecs[4] = '{8'h32, 1'b1, 1'b1, 1'b1, 10'h031, 1'b1, 1'b1};

        #1;
        check("reset_word", {6'd0, rx_word}, 16'h000);
        check("reset_valid", {15'd0, rx_valid}, 16'd0);
        check("reset_overrun", {15'd0, overrun}, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            send_bit(1'b1);
            check($sformatf("vec%0d_word", i), {6'd0, rx_word}, {6'd0, vecs[i].exp_word});
            check($sformatf("vec%0d_valid", i), {15'd0, rx_valid}, {15'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_overrun", i), {15'd0, overrun}, {15'd0, vecs[i].exp_ovr});
            if (vecs[i].ack) begin
                pulse_ack();
                check($sformatf("vec%0d_ack_clears", i), {15'd0, rx_valid}, 16'd0);
            end
        end

        // Glitch shorter than the sample window must be rejected as a false start.
        rx_in = 1'b0;
        repeat (3 * CPT) @(posedge clk);
        #1;
        rx_in = 1'b1;
        check("glitch_busy_seen", {15'd0, busy}, 16'd1);
        repeat (20 * CPT) @(posedge clk);
        #1;
        check("glitch_busy_clear", {15'd0, busy}, 16'd0);
        check("glitch_no_word", {15'd0, rx_valid}, 16'd0);

        // Reset mid-frame while in the data bits.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check("midframe_busy", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        rx_in = 1'b1;
        #1;
        check("midframe_rst_busy", {15'd0, busy}, 16'd0);
        check("midframe_rst_overrun", {15'd0, overrun}, 16'd0);
        check("midframe_rst_word", {6'd0, rx_word}, 16'h000);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2 * FRAME_CYC) @(posedge clk);
        #1;
        check("midframe_no_word", {15'd0, rx_valid}, 16'd0);
        check("midframe_idle", {15'd0, busy}, 16'd0);

        // Ack coincident with a completion: new word loaded, no overrun.
        do_reset();
        send_frame(8'h31, 1'b1, 1'b1);
        send_bit(1'b1);
        check("ackcomp_first_word", {6'd0, rx_word}, 16'h031);
        fork
            send_frame(8'h32, 1'b1, 1'b1);
            begin
                repeat (2 + (10 * OS + OS / 2 + 2) * CPT) @(posedge clk);
                #1;
                rx_ack = 1'b1;
                @(posedge clk);
                #1;
                rx_ack = 1'b0;
            end
        join
        send_bit(1'b1);
        check("ackcomp_word", {6'd0, rx_word}, 16'h032);
        check("ackcomp_valid", {15'd0, rx_valid}, 16'd1);
        check("ackcomp_overrun", {15'd0, overrun}, 16'd0);
        pulse_ack();

        // Back-to-back frames with no idle gap.
        fork
            begin
                send_frame(8'hA5, 1'b0, 1'b1);
                send_frame(8'h5A, 1'b0, 1'b1);
            end
            begin
                wait_valid("b2b_first_valid", 2 * FRAME_CYC);
                check("b2b_first_word", {6'd0, rx_word}, 16'h0A5);
                pulse_ack();
                wait_valid("b2b_second_valid", 2 * FRAME_CYC);
                check("b2b_second_word", {6'd0, rx_word}, 16'h05A);
                pulse_ack();
            end
        join
        send_bit(1'b1);
        check("b2b_overrun", {15'd0, overrun}, 16'd0);
        check("b2b_idle", {15'd0, busy}, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
